idma_desc64_fetch_ctrl: RTL and testbench
=========================================

Name: idma_desc64_fetch_ctrl

Overview:
Sequences descriptor fetches for the desc64 frontend. It accepts chain head addresses and issues one AXI AR burst per 256-bit descriptor. It follows each chain through the next-descriptor address reported by the descriptor reader, until it sees the end-of-chain marker (all ones). A credit counter limits in-flight fetches to the free space of the downstream iDMA request FIFO, so the reader's "FIFO always has space" requirement holds by construction.

Parameters:
AddrWidth, 64, AXI address width; only 64 is supported.
DataWidth, 64, AXI data width; legal values 32/64/128/256, all others rejected by elaboration assertion.
NumCredits, 4, depth of the downstream request FIFO; legal range 1..15.
addr_t, logic [AddrWidth-1:0], address type.

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
head_addr_i  in  AddrWidth  first descriptor address of a new chain
head_valid_i  in  1  head_addr_i valid
head_ready_o  out  1  head accepted; asserted only in IDLE
ar_addr_o  out  AddrWidth  AR address
ar_len_o  out  8  AR burst length; (256/DataWidth)-1
ar_size_o  out  3  AR size; log2(DataWidth/8)
ar_burst_o  out  2  AR burst type; constant 2'b01 (INCR)
ar_valid_o  out  1  AR valid
ar_ready_i  in  1  AR ready
next_addr_i  in  AddrWidth  next-descriptor address from the reader
next_addr_valid_i  in  1  next_addr_i valid; may stay high for several cycles
req_pop_i  in  1  one-cycle pulse per entry popped from the downstream request FIFO
chain_done_o  out  1  one-cycle pulse when the end-of-chain marker is captured
busy_o  out  1  high in any state other than IDLE
credits_o  out  $clog2(NumCredits+1)  current free credits, for debug

Behaviour:
- Reset values: state IDLE, credits = NumCredits, addr_q = 0, seen_q = 0. All valid and pulse outputs are 0, and ar_addr_o = 0.
- ar_len_o, ar_size_o and ar_burst_o are constant, derived from DataWidth.
  - DataWidth 256: len 0, size 5. DataWidth 128: len 1, size 4.
  - DataWidth 64: len 3, size 3. DataWidth 32: len 7, size 2.
- FSM states: IDLE, ISSUE, WAIT_NEXT.
  - IDLE: head_ready_o = 1. On head_valid_i, latch addr_q = head_addr_i and go to ISSUE. There is no AR in the same cycle; the first AR comes 1 cycle after head acceptance.
  - ISSUE: ar_valid_o = (credits != 0) and ar_addr_o = addr_q. With zero credits, ar_valid_o stays low and the FSM waits.
  - ISSUE, on the ar_valid_o && ar_ready_i handshake: credits decrement, go to WAIT_NEXT.
  - ISSUE: once ar_valid_o is asserted, it stays high and ar_addr_o stays stable until the handshake (AXI rule). A credit cannot be lost while valid is high, because only handshakes consume credits.
  - WAIT_NEXT: capture next_addr_i on a cycle where next_addr_valid_i && !seen_q.
    - If next_addr_i == all ones: pulse chain_done_o and go to IDLE.
    - Otherwise: addr_q = next_addr_i and go to ISSUE.
- seen_q blocks re-capturing a valid that is held across a stalled R beat.
  - Set on capture; cleared on any cycle where next_addr_valid_i = 0.
  - next_addr_valid_i in IDLE or ISSUE is ignored for capture, but still clears or holds seen_q per the same rule.
- Credits: on the same cycle, +1 on req_pop_i and -1 on an AR handshake. Both together leave the count unchanged.
  - req_pop_i when credits == NumCredits is a protocol error: an assertion fires and the count saturates.
- Only one descriptor per chain is outstanding, because the next address is unknown until the current descriptor returns. Extra credits allow fetches of a new chain to overlap the draining of the FIFO.
- head_ready_o is low outside IDLE. A new head is held off until the current chain ends.
- Addresses are not checked for alignment. Software guarantees 32-byte alignment, so a burst never crosses 4 KiB.
- Reset mid-operation: all state returns to reset values immediately (asynchronous), including a drop of an asserted ar_valid_o. Credits are restored to NumCredits.

Test Plan:
- Single descriptor, DataWidth=64: head 0x1000 -> AR addr 0x1000, len 3, size 3, burst 1 on cycle+1. Then next_addr_i = 0xFFFF_FFFF_FFFF_FFFF -> chain_done_o pulse, state IDLE, credits 3.
- Three-descriptor chain 0x1000->0x2000->0x3000->end, ar_ready_i always 1 -> ARs issued in that order, one per next_addr capture. Exactly one chain_done_o pulse; credits go 4,3,2,1.
- Credit stall, NumCredits=2 with no req_pop_i: two-descriptor chain then a third link -> third AR held with ar_valid_o=0. One req_pop_i pulse -> AR issues the next cycle.
- AR backpressure: ar_ready_i low for 5 cycles in ISSUE -> ar_valid_o stays high, ar_addr_o stays stable, credits stay unchanged until the handshake.
- next_addr_valid_i held high for 4 cycles, value 0x2000 -> exactly one capture and one AR to 0x2000, with no duplicate fetch.
- Simultaneous req_pop_i and AR handshake -> credits unchanged. rst_ni asserted during ISSUE -> ar_valid_o drops at once, credits = NumCredits, head_ready_o = 1 after reset release.

Source files
------------

// File: rtl/idma_desc64_fetch_ctrl.sv
// Descriptor fetch sequencer for the desc64 frontend: issues one AR burst per 256-bit
// descriptor, follows next-descriptor links and bounds in-flight fetches with credits.
module idma_desc64_fetch_ctrl #(
  parameter int unsigned AddrWidth  = 64,
  parameter int unsigned DataWidth  = 64,
  parameter int unsigned NumCredits = 4,
  parameter type         addr_t     = logic [AddrWidth-1:0],
  localparam int unsigned CreditWidth = $clog2(NumCredits + 1)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  addr_t                  head_addr_i,
  input  logic                   head_valid_i,
  output logic                   head_ready_o,
  output addr_t                  ar_addr_o,
  output logic [7:0]             ar_len_o,
  output logic [2:0]             ar_size_o,
  output logic [1:0]             ar_burst_o,
  output logic                   ar_valid_o,
  input  logic                   ar_ready_i,
  input  addr_t                  next_addr_i,
  input  logic                   next_addr_valid_i,
  input  logic                   req_pop_i,
  output logic                   chain_done_o,
  output logic                   busy_o,
  output logic [CreditWidth-1:0] credits_o
);

  if (AddrWidth != 64) begin : gen_addr_width_check
    $error("idma_desc64_fetch_ctrl: AddrWidth must be 64");
  end
  if (!(DataWidth == 32 || DataWidth == 64 || DataWidth == 128 || DataWidth == 256))
  begin : gen_data_width_check
    $error("idma_desc64_fetch_ctrl: DataWidth must be 32, 64, 128 or 256");
  end
  if (NumCredits < 1 || NumCredits > 15) begin : gen_credit_check
    $error("idma_desc64_fetch_ctrl: NumCredits must be in 1..15");
  end

  localparam logic [CreditWidth-1:0] MaxCredits = CreditWidth'(NumCredits);

  typedef enum logic [1:0] {StIdle, StIssue, StWaitNext} state_e;

  state_e                 state_q, state_d;
  addr_t                  addr_q, addr_d;
  logic                   seen_q, seen_d;
  logic                   done_q, done_d;
  logic [CreditWidth-1:0] credits_q, credits_d;
  logic                   ar_hs;
  logic                   capture;

  // One descriptor is exactly one 256-bit burst.
  assign ar_len_o   = 8'(256 / DataWidth - 1);
  assign ar_size_o  = 3'($clog2(DataWidth / 8));
  assign ar_burst_o = 2'b01;
  assign ar_addr_o  = addr_q;

  assign chain_done_o = done_q;
  assign busy_o       = (state_q != StIdle);
  assign credits_o    = credits_q;

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    done_d       = 1'b0;
    head_ready_o = 1'b0;
    ar_valid_o   = 1'b0;
    capture      = 1'b0;
    unique case (state_q)
      StIdle: begin
        head_ready_o = 1'b1;
        if (head_valid_i) begin
          addr_d  = head_addr_i;
          state_d = StIssue;
        end
      end
      StIssue: begin
        // Valid cannot drop once raised: only a handshake consumes a credit.
        ar_valid_o = (credits_q != '0);
        if (ar_valid_o && ar_ready_i) state_d = StWaitNext;
      end
      StWaitNext: begin
        if (next_addr_valid_i && !seen_q) begin
          capture = 1'b1;
          if (next_addr_i == '1) begin
            done_d  = 1'b1;
            state_d = StIdle;
          end else begin
            addr_d  = next_addr_i;
            state_d = StIssue;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    ar_hs = ar_valid_o && ar_ready_i;
    // A valid held across a stalled R beat must not be captured twice.
    seen_d = next_addr_valid_i && (seen_q || capture);

    credits_d = credits_q;
    if (req_pop_i && !ar_hs && (credits_q != MaxCredits)) begin
      credits_d = credits_q + 1'b1;
    end else if (ar_hs && !req_pop_i) begin
      credits_d = credits_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      seen_q    <= 1'b0;
      done_q    <= 1'b0;
      credits_q <= MaxCredits;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      seen_q    <= seen_d;
      done_q    <= done_d;
      credits_q <= credits_d;
    end
  end

  credit_overflow_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(req_pop_i && (credits_q == MaxCredits)))
    else $error("req_pop_i while all credits are free");

endmodule

// File: tb/tb_idma_desc64_fetch_ctrl.sv
// Self-checking bench for idma_desc64_fetch_ctrl: directed scenarios plus randomized chains
// checked against a transaction-level model (expected AR order, credit count, done pulses).
module tb_idma_desc64_fetch_ctrl;
  localparam int unsigned N  = 4;
  localparam int unsigned CW = $clog2(N + 1);
  localparam logic [63:0] EndMark = 64'hFFFF_FFFF_FFFF_FFFF;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic [63:0]   head_addr_i, ar_addr_o, next_addr_i;
  logic          head_valid_i, head_ready_o, ar_valid_o, ar_ready_i;
  logic [7:0]    ar_len_o;
  logic [2:0]    ar_size_o;
  logic [1:0]    ar_burst_o;
  logic          next_addr_valid_i, req_pop_i, chain_done_o, busy_o;
  logic [CW-1:0] credits_o;

  int n_cmp = 0;
  int n_fail = 0;
  int m_credits;
  int done_cnt;
  logic [63:0] ar_log[$];

  idma_desc64_fetch_ctrl #(.AddrWidth(64), .DataWidth(64), .NumCredits(N)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .head_addr_i(head_addr_i), .head_valid_i(head_valid_i),
    .head_ready_o(head_ready_o), .ar_addr_o(ar_addr_o), .ar_len_o(ar_len_o),
    .ar_size_o(ar_size_o), .ar_burst_o(ar_burst_o), .ar_valid_o(ar_valid_o),
    .ar_ready_i(ar_ready_i), .next_addr_i(next_addr_i), .next_addr_valid_i(next_addr_valid_i),
    .req_pop_i(req_pop_i), .chain_done_o(chain_done_o), .busy_o(busy_o), .credits_o(credits_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, got running want finished");
    $fatal(1, "timeout");
  end

  task automatic drive_idle();
    head_valid_i = 1'b0; head_addr_i = '0; ar_ready_i = 1'b0;
    next_addr_valid_i = 1'b0; next_addr_i = '0; req_pop_i = 1'b0;
  endtask

  // Advance one clock; update the transaction model from what crossed the edge.
  task automatic tick();
    logic hs, pop;
    logic [63:0] a;
    hs = ar_valid_o && ar_ready_i;
    pop = req_pop_i;
    a = ar_addr_o;
    @(posedge clk_i);
    #1;
    if (hs) ar_log.push_back(a);
    if (pop && !hs && m_credits < N) m_credits++;
    else if (hs && !pop) m_credits--;
    if (chain_done_o) done_cnt++;
  endtask

  task automatic refill();
    while (m_credits < int'(N)) begin
      req_pop_i = 1'b1;
      tick();
    end
    req_pop_i = 1'b0;
  endtask

  task automatic test_reset();
    drive_idle();
    rst_ni = 1'b0;
    #12;
    n_cmp++; if (ar_valid_o !== 1'b0) begin n_fail++;
      $display("FAIL reset_ar_valid: got %0b want 0", ar_valid_o); end
    rst_ni = 1'b1;
    m_credits = N;
    @(posedge clk_i); #1;
    n_cmp++; if (head_ready_o !== 1'b1 || busy_o !== 1'b0 || chain_done_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_status: got ready=%0b busy=%0b done=%0b want 1 0 0",
                         head_ready_o, busy_o, chain_done_o); end
    n_cmp++; if (credits_o !== CW'(N) || ar_addr_o !== 64'h0) begin n_fail++;
      $display("FAIL reset_credits_addr: got %0d %h want %0d 0", credits_o, ar_addr_o, N); end
    n_cmp++; if (ar_len_o !== 8'd3 || ar_size_o !== 3'd3 || ar_burst_o !== 2'b01) begin
      n_fail++; $display("FAIL ar_consts: got len=%0d size=%0d burst=%0d want 3 3 1",
                         ar_len_o, ar_size_o, ar_burst_o); end
  endtask

  task automatic test_single_backpressure();
    ar_log.delete(); done_cnt = 0;
    head_addr_i = 64'h1000; head_valid_i = 1'b1; tick(); head_valid_i = 1'b0;
    n_cmp++; if (ar_valid_o !== 1'b1 || ar_addr_o !== 64'h1000 || head_ready_o !== 1'b0) begin
      n_fail++; $display("FAIL single_first_ar: got v=%0b a=%h rdy=%0b want 1 1000 0",
                         ar_valid_o, ar_addr_o, head_ready_o); end
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++; if (ar_valid_o !== 1'b1 || ar_addr_o !== 64'h1000 || credits_o !== CW'(N)) begin
        n_fail++; $display("FAIL backpressure_hold: got v=%0b a=%h c=%0d want 1 1000 %0d",
                           ar_valid_o, ar_addr_o, credits_o, N); end
    end
    ar_ready_i = 1'b1; tick(); ar_ready_i = 1'b0;
    n_cmp++; if (ar_log.size() != 1 || credits_o !== CW'(N - 1) || ar_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL single_handshake: got n=%0d c=%0d v=%0b want 1 %0d 0",
                         ar_log.size(), credits_o, ar_valid_o, N - 1); end
    next_addr_i = EndMark; next_addr_valid_i = 1'b1; tick(); next_addr_valid_i = 1'b0;
    n_cmp++; if (chain_done_o !== 1'b1 || head_ready_o !== 1'b1 || credits_o !== CW'(N - 1))
    begin n_fail++; $display("FAIL single_done: got done=%0b rdy=%0b c=%0d want 1 1 %0d",
                             chain_done_o, head_ready_o, credits_o, N - 1); end
    tick();
    n_cmp++; if (chain_done_o !== 1'b0 || done_cnt != 1) begin n_fail++;
      $display("FAIL single_done_pulse: got done=%0b cnt=%0d want 0 1", chain_done_o, done_cnt);
    end
    refill();
  endtask

  task automatic test_chain3();
    logic [63:0] exp_a[3];
    exp_a[0] = 64'h1000; exp_a[1] = 64'h2000; exp_a[2] = 64'h3000;
    ar_log.delete(); done_cnt = 0;
    ar_ready_i = 1'b1;
    head_addr_i = exp_a[0]; head_valid_i = 1'b1; tick(); head_valid_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (credits_o !== CW'(N - i)) begin n_fail++;
        $display("FAIL chain3_credits_before: got %0d want %0d", credits_o, N - i); end
      tick();
      n_cmp++; if (credits_o !== CW'(N - 1 - i)) begin n_fail++;
        $display("FAIL chain3_credits_after: got %0d want %0d", credits_o, N - 1 - i); end
      next_addr_i = (i < 2) ? exp_a[i + 1] : EndMark;
      next_addr_valid_i = 1'b1; tick(); next_addr_valid_i = 1'b0;
    end
    tick(); ar_ready_i = 1'b0;
    n_cmp++; if (ar_log.size() != 3 || ar_log[0] !== exp_a[0] || ar_log[1] !== exp_a[1] ||
                 ar_log[2] !== exp_a[2] || done_cnt != 1) begin n_fail++;
      $display("FAIL chain3_order: got n=%0d done=%0d want 3 ARs 1000,2000,3000 and 1 done",
               ar_log.size(), done_cnt); end
    refill();
  endtask

  task automatic test_hold_valid();
    ar_log.delete(); done_cnt = 0;
    head_addr_i = 64'h1000; head_valid_i = 1'b1; tick(); head_valid_i = 1'b0;
    ar_ready_i = 1'b1; tick();
    next_addr_i = 64'h2000; next_addr_valid_i = 1'b1;
    repeat (4) tick();
    next_addr_valid_i = 1'b0; ar_ready_i = 1'b0; tick();
    n_cmp++; if (ar_log.size() != 2 || ar_log[1] !== 64'h2000 || busy_o !== 1'b1) begin
      n_fail++; $display("FAIL hold_single_capture: got n=%0d busy=%0b want 2 ARs busy 1",
                         ar_log.size(), busy_o); end
    next_addr_i = EndMark; next_addr_valid_i = 1'b1; tick(); next_addr_valid_i = 1'b0; tick();
    n_cmp++; if (ar_log.size() != 2 || done_cnt != 1 || head_ready_o !== 1'b1) begin n_fail++;
      $display("FAIL hold_end: got n=%0d done=%0d rdy=%0b want 2 1 1",
               ar_log.size(), done_cnt, head_ready_o); end
    refill();
  endtask

  task automatic test_credit_stall();
    ar_log.delete(); done_cnt = 0;
    head_addr_i = 64'h1000; head_valid_i = 1'b1; tick(); head_valid_i = 1'b0;
    for (int i = 0; i < int'(N); i++) begin
      ar_ready_i = 1'b1; tick(); ar_ready_i = 1'b0;
      next_addr_i = 64'h1000 + 64'(i + 1) * 64'h20;
      next_addr_valid_i = 1'b1; tick(); next_addr_valid_i = 1'b0;
    end
    ar_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (ar_valid_o !== 1'b0 || credits_o !== '0 || busy_o !== 1'b1) begin n_fail++;
        $display("FAIL stall_no_credit: got v=%0b c=%0d want 0 0", ar_valid_o, credits_o); end
      tick();
    end
    ar_ready_i = 1'b0; req_pop_i = 1'b1; tick(); req_pop_i = 1'b0;
    n_cmp++; if (ar_valid_o !== 1'b1 || ar_addr_o !== 64'h1000 + 64'(N) * 64'h20) begin
      n_fail++; $display("FAIL stall_release: got v=%0b a=%h want 1 %h", ar_valid_o, ar_addr_o,
                         64'h1000 + 64'(N) * 64'h20); end
    ar_ready_i = 1'b1; tick(); ar_ready_i = 1'b0;
    n_cmp++; if (ar_log.size() != N + 1 || credits_o !== '0) begin n_fail++;
      $display("FAIL stall_issue: got n=%0d c=%0d want %0d 0", ar_log.size(), credits_o, N + 1);
    end
    next_addr_i = EndMark; next_addr_valid_i = 1'b1; tick(); next_addr_valid_i = 1'b0;
    refill();
  endtask

  task automatic test_simul_pop_and_reset();
    head_addr_i = 64'h4000; head_valid_i = 1'b1; tick(); head_valid_i = 1'b0;
    ar_ready_i = 1'b1; tick(); ar_ready_i = 1'b0;
    next_addr_i = 64'h4020; next_addr_valid_i = 1'b1; tick(); next_addr_valid_i = 1'b0;
    ar_ready_i = 1'b1; req_pop_i = 1'b1; tick(); ar_ready_i = 1'b0; req_pop_i = 1'b0;
    n_cmp++; if (credits_o !== CW'(N - 1) || credits_o !== CW'(m_credits)) begin n_fail++;
      $display("FAIL simul_pop_hs: got %0d want %0d", credits_o, N - 1); end
    next_addr_i = 64'h4040; next_addr_valid_i = 1'b1; tick(); next_addr_valid_i = 1'b0;
    n_cmp++; if (ar_valid_o !== 1'b1) begin n_fail++;
      $display("FAIL pre_reset_valid: got %0b want 1", ar_valid_o); end
    #2 rst_ni = 1'b0;
    #1;
    n_cmp++; if (ar_valid_o !== 1'b0 || credits_o !== CW'(N) || busy_o !== 1'b0) begin
      n_fail++; $display("FAIL async_reset: got v=%0b c=%0d busy=%0b want 0 %0d 0",
                         ar_valid_o, credits_o, busy_o, N); end
    m_credits = N;
    @(negedge clk_i); rst_ni = 1'b1;
    @(posedge clk_i); #1;
    n_cmp++; if (head_ready_o !== 1'b1 || ar_addr_o !== 64'h0) begin n_fail++;
      $display("FAIL post_reset: got rdy=%0b a=%h want 1 0", head_ready_o, ar_addr_o); end
  endtask

  task automatic test_random_chains();
    for (int c = 0; c < 20; c++) begin
      int len;
      int guard;
      logic got_hs, pv, ok;
      logic [63:0] pa;
      logic [63:0] addrs[$];
      len = $urandom_range(1, 5);
      ar_log.delete(); done_cnt = 0;
      for (int i = 0; i < len; i++) addrs.push_back({$urandom, $urandom} & ~64'h1F);
      head_addr_i = addrs[0]; head_valid_i = 1'b1; tick(); head_valid_i = 1'b0;
      for (int i = 0; i < len; i++) begin
        guard = 0; got_hs = 1'b0;
        while (!got_hs && guard < 200) begin
          ar_ready_i = ($urandom_range(0, 2) != 0);
          req_pop_i = (m_credits < int'(N)) && ($urandom_range(0, 3) == 0);
          head_valid_i = $urandom_range(0, 1);
          head_addr_i = {$urandom, $urandom};
          got_hs = ar_valid_o && ar_ready_i;
          pv = ar_valid_o && !ar_ready_i;
          pa = ar_addr_o;
          tick();
          if (pv) begin
            n_cmp++; if (ar_valid_o !== 1'b1 || ar_addr_o !== pa) begin n_fail++;
              $display("FAIL rand_ar_stable: got v=%0b a=%h want 1 %h", ar_valid_o, ar_addr_o,
                       pa); end
          end
          guard++;
        end
        ar_ready_i = 1'b0; req_pop_i = 1'b0; head_valid_i = 1'b0;
        if (!got_hs) begin
          n_cmp++; n_fail++;
          $display("FAIL rand_ar_timeout: got no handshake want handshake (chain %0d)", c);
        end
        repeat ($urandom_range(0, 2)) tick();
        next_addr_i = (i == len - 1) ? EndMark : addrs[i + 1];
        next_addr_valid_i = 1'b1;
        repeat ($urandom_range(1, 4)) tick();
        next_addr_valid_i = 1'b0; tick();
      end
      tick();
      ok = (ar_log.size() == len);
      for (int i = 0; i < len && ok; i++) if (ar_log[i] !== addrs[i]) ok = 1'b0;
      n_cmp++; if (!ok) begin n_fail++;
        $display("FAIL rand_ar_order: got %0d ARs want %0d in chain order", ar_log.size(), len);
      end
      n_cmp++; if (done_cnt != 1 || head_ready_o !== 1'b1 || credits_o !== CW'(m_credits)) begin
        n_fail++; $display("FAIL rand_end: got done=%0d rdy=%0b c=%0d want 1 1 %0d",
                           done_cnt, head_ready_o, credits_o, m_credits); end
    end
    refill();
  endtask

  initial begin
    m_credits = N;
    done_cnt = 0;
    test_reset();
    test_single_backpressure();
    test_chain3();
    test_hold_valid();
    test_credit_stall();
    test_simul_pop_and_reset();
    test_random_chains();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
